alt_mem_ddrx_mm_st_burst_converter: RTL and testbench

Converts an Avalon-MM master request stream into the controller's Avalon-ST channels: one command channel, one multi-beat write-data channel and one read-data channel. It generates sequential command IDs and write begin/last framing, and tags write beats with the command ID. It limits in-flight read beats with a credit counter and can optionally register the read-return path. It sits between the user Avalon slave port and the controller input interface.

---
 rtl/alt_mem_ddrx_mm_st_burst_converter.sv | 127 ++++++++++++
 tb/tb_alt_mem_ddrx_mm_st_burst_converter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alt_mem_ddrx_mm_st_burst_converter.sv
// alt_mem_ddrx_mm_st_burst_converter: Avalon-MM requests to controller command/write/read ST channels
module alt_mem_ddrx_mm_st_burst_converter #(
  parameter int AVL_SIZE_WIDTH     = 3,
  parameter int AVL_ADDR_WIDTH     = 25,
  parameter int AVL_DATA_WIDTH     = 32,
  parameter int LOCAL_ID_WIDTH     = 8,
  parameter int MAX_RD_OUTSTANDING = 16,
  parameter int CFG_MM_ST_CONV_REG = 0,
  localparam int BE_WIDTH = AVL_DATA_WIDTH / 8,
  localparam int OW = $clog2(MAX_RD_OUTSTANDING + 1)
) (
  input  logic                      ctl_clk,
  input  logic                      ctl_reset,
  output logic                      avl_ready,
  input  logic                      avl_read_req,
  input  logic                      avl_write_req,
  input  logic [AVL_SIZE_WIDTH-1:0] avl_size,
  input  logic [AVL_ADDR_WIDTH-1:0] avl_addr,
  input  logic [AVL_DATA_WIDTH-1:0] avl_wdata,
  input  logic [BE_WIDTH-1:0]       avl_be,
  input  logic                      local_priority,
  input  logic                      local_autopch_req,
  output logic                      avl_rdata_valid,
  output logic [AVL_DATA_WIDTH-1:0] avl_rdata,
  output logic                      avl_rdata_error,
  input  logic                      itf_cmd_ready,
  output logic                      itf_cmd_valid,
  output logic                      itf_cmd,
  output logic [AVL_ADDR_WIDTH-1:0] itf_cmd_address,
  output logic [AVL_SIZE_WIDTH-1:0] itf_cmd_burstlen,
  output logic [LOCAL_ID_WIDTH-1:0] itf_cmd_id,
  output logic                      itf_cmd_priority,
  output logic                      itf_cmd_autopercharge,
  input  logic                      itf_wr_data_ready,
  output logic                      itf_wr_data_valid,
  output logic [AVL_DATA_WIDTH-1:0] itf_wr_data,
  output logic [BE_WIDTH-1:0]       itf_wr_data_byte_en,
  output logic                      itf_wr_data_begin,
  output logic                      itf_wr_data_last,
  output logic [LOCAL_ID_WIDTH-1:0] itf_wr_data_id,
  output logic                      itf_rd_data_ready,
  input  logic                      itf_rd_data_valid,
  input  logic [AVL_DATA_WIDTH-1:0] itf_rd_data,
  input  logic                      itf_rd_data_error,
  output logic [OW-1:0]             rd_outstanding,
  output logic                      rd_underflow
);
  localparam int CW = (OW > AVL_SIZE_WIDTH ? OW : AVL_SIZE_WIDTH) + 1;
  typedef enum logic {IDLE, WR_DATA} state_t;
  state_t r_state, w_state_nxt;
  logic [AVL_SIZE_WIDTH-1:0] r_cnt;
  logic [LOCAL_ID_WIDTH-1:0] r_id, r_wr_id;
  logic [AVL_SIZE_WIDTH-1:0] w_eff_size;
  logic [CW-1:0]             w_credit_sum;
  logic w_idle, w_in_wr, w_credit_ok, w_wr_go, w_rd_req, w_rd_go, w_beat, w_rd_dec, w_eff_one;
  assign w_eff_size   = (avl_size == '0) ? AVL_SIZE_WIDTH'(1) : avl_size;
  assign w_eff_one    = w_eff_size == AVL_SIZE_WIDTH'(1);
  assign w_credit_sum = CW'(rd_outstanding) + CW'(w_eff_size);
  assign w_credit_ok  = w_credit_sum <= CW'(MAX_RD_OUTSTANDING);
  assign w_idle       = r_state == IDLE && !ctl_reset;
  assign w_in_wr      = r_state == WR_DATA && !ctl_reset;
  assign w_wr_go      = w_idle && avl_write_req && itf_cmd_ready && itf_wr_data_ready;
  assign w_rd_req     = w_idle && !avl_write_req && avl_read_req && w_credit_ok;
  assign w_rd_go      = w_rd_req && itf_cmd_ready;
  assign w_beat       = w_in_wr && avl_write_req && itf_wr_data_ready;
  assign w_rd_dec     = itf_rd_data_valid && rd_outstanding != '0;
  assign avl_ready             = w_wr_go || w_rd_go || (w_in_wr && itf_wr_data_ready);
  assign itf_cmd_valid         = w_wr_go || w_rd_req;
  assign itf_cmd               = avl_write_req;
  assign itf_cmd_address       = avl_addr;
  assign itf_cmd_burstlen      = w_eff_size;
  assign itf_cmd_id            = r_id;
  assign itf_cmd_priority      = local_priority;
  assign itf_cmd_autopercharge = local_autopch_req;
  assign itf_wr_data_valid     = w_wr_go || (w_in_wr && avl_write_req);
  assign itf_wr_data           = avl_wdata;
  assign itf_wr_data_byte_en   = avl_be;
  assign itf_wr_data_begin     = r_state == IDLE;
  assign itf_wr_data_last      = (r_state == IDLE) ? w_eff_one : r_cnt == AVL_SIZE_WIDTH'(1);
  assign itf_wr_data_id        = (r_state == IDLE) ? r_id : r_wr_id;
  assign itf_rd_data_ready     = 1'b1;
  // Multi-beat writes park in WR_DATA until the last beat is accepted
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE)
      w_state_nxt = (w_wr_go && !w_eff_one) ? WR_DATA : IDLE;
    else
      w_state_nxt = (w_beat && r_cnt == AVL_SIZE_WIDTH'(1)) ? IDLE : WR_DATA;
  end
  // State, beat counter, command IDs and read credit bookkeeping
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_id           <= '0;
      r_wr_id        <= '0;
      rd_outstanding <= '0;
      rd_underflow   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_go) r_cnt <= w_eff_size - AVL_SIZE_WIDTH'(1);
      else if (w_beat) r_cnt <= r_cnt - AVL_SIZE_WIDTH'(1);
      if (w_wr_go) r_wr_id <= r_id;
      if (w_wr_go || w_rd_go) r_id <= r_id + LOCAL_ID_WIDTH'(1);
      rd_outstanding <= rd_outstanding + (w_rd_go ? OW'(w_eff_size) : '0) - OW'(w_rd_dec);
      if (itf_rd_data_valid && rd_outstanding == '0) rd_underflow <= 1'b1;
    end
  end
  if (CFG_MM_ST_CONV_REG != 0) begin : g_rd_reg
    // Registered read return: one cycle of latency, never backpressured
    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
      if (ctl_reset) begin
        avl_rdata_valid <= 1'b0;
        avl_rdata       <= '0;
        avl_rdata_error <= 1'b0;
      end else begin
        avl_rdata_valid <= itf_rd_data_valid;
        avl_rdata       <= itf_rd_data;
        avl_rdata_error <= itf_rd_data_error;
      end
    end
  end else begin : g_rd_comb
    assign avl_rdata_valid = itf_rd_data_valid;
    assign avl_rdata       = itf_rd_data;
    assign avl_rdata_error = itf_rd_data_error;
  end
endmodule

// File: tb/tb_alt_mem_ddrx_mm_st_burst_converter.sv
// tb_alt_mem_ddrx_mm_st_burst_converter: scoreboard bench for the MM-to-ST burst converter
module tb_alt_mem_ddrx_mm_st_burst_converter;
  logic        clk = 0;
  logic        rst = 1;
  logic        avl_ready, avl_read_req = 0, avl_write_req = 0;
  logic [2:0]  avl_size = 0;
  logic [24:0] avl_addr = 0;
  logic [31:0] avl_wdata = 0;
  logic [3:0]  avl_be = 4'hF;
  logic        avl_rdata_valid, avl_rdata_error;
  logic [31:0] avl_rdata;
  logic        itf_cmd_ready = 1, itf_cmd_valid, itf_cmd;
  logic [24:0] itf_cmd_address;
  logic [2:0]  itf_cmd_burstlen;
  logic [7:0]  itf_cmd_id, itf_wr_data_id;
  logic        itf_cmd_priority, itf_cmd_autopercharge;
  logic        itf_wr_data_ready = 1, itf_wr_data_valid, itf_wr_data_begin, itf_wr_data_last;
  logic [31:0] itf_wr_data;
  logic [3:0]  itf_wr_data_byte_en;
  logic        itf_rd_data_ready, itf_rd_data_valid = 0, itf_rd_data_error = 0;
  logic [31:0] itf_rd_data = 0;
  logic [3:0]  rd_outstanding;
  logic        rd_underflow;
  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  logic [7:0] exp_id = 0;
  logic [63:0] cmd_q[$], wr_q[$], rd_q[$];

  alt_mem_ddrx_mm_st_burst_converter #(
    .AVL_SIZE_WIDTH(3), .AVL_ADDR_WIDTH(25), .AVL_DATA_WIDTH(32), .LOCAL_ID_WIDTH(8),
    .MAX_RD_OUTSTANDING(8), .CFG_MM_ST_CONV_REG(1)
  ) dut (
    .ctl_clk(clk), .ctl_reset(rst), .avl_ready(avl_ready), .avl_read_req(avl_read_req),
    .avl_write_req(avl_write_req), .avl_size(avl_size), .avl_addr(avl_addr), .avl_wdata(avl_wdata),
    .avl_be(avl_be), .local_priority(1'b0), .local_autopch_req(1'b0),
    .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata), .avl_rdata_error(avl_rdata_error),
    .itf_cmd_ready(itf_cmd_ready), .itf_cmd_valid(itf_cmd_valid), .itf_cmd(itf_cmd),
    .itf_cmd_address(itf_cmd_address), .itf_cmd_burstlen(itf_cmd_burstlen), .itf_cmd_id(itf_cmd_id),
    .itf_cmd_priority(itf_cmd_priority), .itf_cmd_autopercharge(itf_cmd_autopercharge),
    .itf_wr_data_ready(itf_wr_data_ready), .itf_wr_data_valid(itf_wr_data_valid),
    .itf_wr_data(itf_wr_data), .itf_wr_data_byte_en(itf_wr_data_byte_en),
    .itf_wr_data_begin(itf_wr_data_begin), .itf_wr_data_last(itf_wr_data_last),
    .itf_wr_data_id(itf_wr_data_id), .itf_rd_data_ready(itf_rd_data_ready),
    .itf_rd_data_valid(itf_rd_data_valid), .itf_rd_data(itf_rd_data),
    .itf_rd_data_error(itf_rd_data_error), .rd_outstanding(rd_outstanding), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [24:0] a, input logic [2:0] len);
    cmd_q.push_back({27'd0, w, a, len, exp_id});
    exp_id++;
  endtask

  task automatic push_wr(input logic [31:0] d, input logic b, input logic l, input logic [7:0] id);
    wr_q.push_back({22'd0, d, b, l, id});
  endtask

  task automatic drive_rd(input logic [31:0] d, input logic e);
    itf_rd_data_valid = 1;
    itf_rd_data = d;
    itf_rd_data_error = e;
    rd_q.push_back({d, e, 31'(cyc + 1)});
  endtask

  // Monitor: pops the scoreboard on every transfer the DUT presents
  always @(negedge clk) begin
    if (itf_cmd_valid && itf_cmd_ready) begin
      if (cmd_q.size() == 0) chk("cmd_unexpected", {27'd0, itf_cmd, itf_cmd_address, itf_cmd_burstlen, itf_cmd_id}, 64'hDEAD);
      else chk("cmd", {27'd0, itf_cmd, itf_cmd_address, itf_cmd_burstlen, itf_cmd_id}, cmd_q.pop_front());
    end
    if (itf_wr_data_valid && itf_wr_data_ready) begin
      if (wr_q.size() == 0) chk("wr_unexpected", {22'd0, itf_wr_data, itf_wr_data_begin, itf_wr_data_last, itf_wr_data_id}, 64'hDEAD);
      else chk("wr_beat", {22'd0, itf_wr_data, itf_wr_data_begin, itf_wr_data_last, itf_wr_data_id}, wr_q.pop_front());
    end
    if (avl_rdata_valid) begin
      if (rd_q.size() == 0) chk("rd_unexpected", {avl_rdata, avl_rdata_error, 31'(cyc)}, 64'hDEAD);
      else chk("rd_return", {avl_rdata, avl_rdata_error, 31'(cyc)}, rd_q.pop_front());
    end
  end

  initial begin
    logic [31:0] d4 [4];
    d4 = '{32'hD0D0_0000, 32'hD1D1_1111, 32'hD2D2_2222, 32'hD3D3_3333};
    @(negedge clk);
    chk("rst_ready", 64'(avl_ready), 0);
    chk("rst_outstanding", 64'(rd_outstanding), 0);
    chk("rst_rvalid", 64'(avl_rdata_valid), 0);
    avl_write_req = 1; avl_size = 1;
    @(negedge clk);
    chk("rst_valids", {62'd0, itf_cmd_valid, itf_wr_data_valid}, 0);
    tick; avl_write_req = 0; rst = 0;
    // single write, size 1
    tick; avl_write_req = 1; avl_size = 1; avl_addr = 25'h100; avl_wdata = 32'h1111_1111;
    push_wr(32'h1111_1111, 1, 1, exp_id); push_cmd(1, 25'h100, 1);
    @(negedge clk); chk("w1_ready", 64'(avl_ready), 1);
    // write size 4 with a stall on beat 3
    tick; avl_size = 4; avl_addr = 25'h200; avl_wdata = d4[0];
    for (int i = 0; i < 4; i++) push_wr(d4[i], i == 0, i == 3, exp_id);
    push_cmd(1, 25'h200, 4);
    @(negedge clk); chk("w4_b1_ready", 64'(avl_ready), 1);
    tick; avl_wdata = d4[1]; avl_size = 0; avl_addr = 0;
    tick; avl_wdata = d4[2]; itf_wr_data_ready = 0;
    @(negedge clk);
    chk("w4_stall_ready", 64'(avl_ready), 0);
    chk("w4_stall_cmdv", 64'(itf_cmd_valid), 0);
    tick; itf_wr_data_ready = 1;
    tick; avl_wdata = d4[3];
    @(negedge clk); chk("w4_b4_last", 64'(itf_wr_data_last), 1);
    tick; avl_write_req = 0;
    // read credit limit with MAX_RD_OUTSTANDING = 8
    avl_read_req = 1; avl_size = 4; avl_addr = 25'h300; push_cmd(0, 25'h300, 4);
    @(negedge clk); chk("rd1_ready", 64'(avl_ready), 1);
    tick; avl_addr = 25'h304; push_cmd(0, 25'h304, 4);
    @(negedge clk); chk("rd2_ready", 64'(avl_ready), 1);
    tick; avl_size = 1; avl_addr = 25'h308; push_cmd(0, 25'h308, 1);
    @(negedge clk);
    chk("rd3_stall_ready", 64'(avl_ready), 0);
    chk("rd3_stall_cmdv", 64'(itf_cmd_valid), 0);
    chk("rd_out_full", 64'(rd_outstanding), 8);
    tick; drive_rd(32'h1234_5678, 0);
    @(negedge clk); chk("rd3_still_stalled", 64'(avl_ready), 0);
    tick; itf_rd_data_valid = 0;
    @(negedge clk);
    chk("rd_out_7", 64'(rd_outstanding), 7);
    chk("rd3_accept", 64'(avl_ready), 1);
    tick; avl_read_req = 0;
    @(negedge clk); chk("rd_out_8", 64'(rd_outstanding), 8);
    for (int i = 0; i < 8; i++) begin
      tick; drive_rd(32'hC000_0000 + 32'(i), i[0]);
    end
    tick; itf_rd_data_valid = 0;
    @(negedge clk); chk("rd_out_drained", 64'(rd_outstanding), 0);
    // simultaneous read and write: write goes first
    tick; avl_read_req = 1; avl_write_req = 1; avl_size = 1; avl_addr = 25'h400; avl_wdata = 32'h4444_4444;
    push_wr(32'h4444_4444, 1, 1, exp_id); push_cmd(1, 25'h400, 1); push_cmd(0, 25'h400, 1);
    @(negedge clk); chk("both_is_write", {62'd0, itf_cmd, avl_ready}, 3);
    tick; avl_write_req = 0;
    @(negedge clk); chk("then_read", {62'd0, itf_cmd, avl_ready}, 1);
    tick; avl_read_req = 0;
    @(negedge clk); chk("rd_out_1", 64'(rd_outstanding), 1);
    tick; drive_rd(32'hBEEF_0001, 0);
    tick; itf_rd_data_valid = 0;
    @(negedge clk); chk("underflow_clear", {60'd0, rd_outstanding}, 0);
    chk("underflow_pre", 64'(rd_underflow), 0);
    // underflow with registered return
    tick; drive_rd(32'hA5A5_A5A5, 1);
    tick; itf_rd_data_valid = 0;
    @(negedge clk);
    chk("underflow_set", 64'(rd_underflow), 1);
    chk("underflow_cnt0", 64'(rd_outstanding), 0);
    tick;
    @(negedge clk); chk("underflow_sticky", 64'(rd_underflow), 1);
    // reset during beat 2 of a 4-beat write
    tick; avl_write_req = 1; avl_size = 4; avl_addr = 25'h500; avl_wdata = 32'h5555_0000;
    push_wr(32'h5555_0000, 1, 0, exp_id); push_cmd(1, 25'h500, 4);
    tick; avl_wdata = 32'h5555_1111; rst = 1;
    @(negedge clk);
    chk("mid_rst_valids", {61'd0, itf_cmd_valid, itf_wr_data_valid, avl_ready}, 0);
    chk("mid_rst_state", {59'd0, rd_underflow, rd_outstanding}, 0);
    tick; rst = 0; avl_write_req = 0; exp_id = 0;
    tick; avl_write_req = 1; avl_size = 1; avl_addr = 25'h600; avl_wdata = 32'h6666_6666;
    push_wr(32'h6666_6666, 1, 1, exp_id); push_cmd(1, 25'h600, 1);
    @(negedge clk); chk("post_rst_id", 64'(itf_cmd_id), 0);
    tick; avl_write_req = 0;
    tick; tick;
    @(negedge clk);
    chk("cmd_q_empty", 64'(cmd_q.size()), 0);
    chk("wr_q_empty", 64'(wr_q.size()), 0);
    chk("rd_q_empty", 64'(rd_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
